// File: rtl/sram_req_bridge_if.sv
// sram_req_bridge_if: master-side request/acknowledge bus of sram_req_bridge
//   master drives req_i, wr_i, addr_i, wdata_i
//   slave (bridge) returns ack_o, rdata_o, err_o
interface sram_req_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req_i;
   logic              wr_i;
   logic [ADDR_W-1:0] addr_i;
   logic [DATA_W-1:0] wdata_i;
   logic              ack_o;
   logic [DATA_W-1:0] rdata_o;
   logic              err_o;
   modport master (output req_i, wr_i, addr_i, wdata_i, input ack_o, rdata_o, err_o);
   modport slave (input req_i, wr_i, addr_i, wdata_i, output ack_o, rdata_o, err_o);
endinterface

// File: rtl/sram_req_bridge.sv
// sram_req_bridge: serialising req/ack front end for a synchronous SRAM with programmable wait states
//   clk, rst                    clock and synchronous active-high reset
//   bus (slave modport)         req_i/wr_i/addr_i/wdata_i in, ack_o/rdata_o/err_o out
//   sram_addr_o/we_o/wdata_o    word-aligned SRAM command, one-cycle write strobe
//   sram_rdata_i                SRAM read data, valid one cycle after the address
//   MEM_RANGE_CHECK_EN          define to flag accesses at word >= DEPTH_WORDS with err_o
module sram_req_bridge #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 0,
   parameter int DEPTH_WORDS = 16384
) (
   input  logic              clk,
   input  logic              rst,
   sram_req_bridge_if.slave  bus,
   output logic [ADDR_W-1:0] sram_addr_o,
   output logic              sram_we_o,
   output logic [DATA_W-1:0] sram_wdata_o,
   input  logic [DATA_W-1:0] sram_rdata_i
);
`ifdef MEM_RANGE_CHECK_EN
   localparam bit RANGE_CHK = 1'b1;
`else
   localparam bit RANGE_CHK = 1'b0;
`endif
   localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH_WORDS);
   localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
   localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYCLES - 1);
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_RDLAT, S_DONE} state_t;
   state_t            state_q;
   logic [3:0]        cnt_q;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              ack_q;
   logic              err_q;
   logic [DATA_W-1:0] rdata_q;
   logic [ADDR_W-1:0] sram_addr_q;
   logic              sram_we_q;
   logic [DATA_W-1:0] sram_wdata_q;
   logic              in_idle;
   logic              oor;
   logic              go_acc;
   logic              acc_wr;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_wdata;
   // SRAM outputs are registered, so they are loaded on the edge that enters ACCESS;
   // from IDLE (no wait states) that uses the live inputs, otherwise the latched copy.
   always_comb begin
      in_idle   = state_q == S_IDLE;
      oor       = RANGE_CHK && ({2'b00, bus.addr_i[ADDR_W-1:2]} >= DEPTH_LIM);
      acc_wr    = in_idle ? bus.wr_i : wr_q;
      acc_addr  = in_idle ? bus.addr_i : addr_q;
      acc_wdata = in_idle ? bus.wdata_i : wdata_q;
      go_acc    = in_idle ? (bus.req_i && !oor && WAIT_CYCLES == 0) : (state_q == S_WAIT && cnt_q == 4'd0);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         wr_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         ack_q        <= 1'b0;
         err_q        <= 1'b0;
         rdata_q      <= '0;
         sram_addr_q  <= '0;
         sram_we_q    <= 1'b0;
         sram_wdata_q <= '0;
      end else begin
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         sram_we_q <= 1'b0;
         if (go_acc) begin
            sram_addr_q <= acc_addr & WORD_MASK;
            sram_we_q   <= acc_wr;
            if (acc_wr) sram_wdata_q <= acc_wdata;
         end
         case (state_q)
            S_IDLE: if (bus.req_i) begin
               wr_q    <= bus.wr_i;
               addr_q  <= bus.addr_i;
               wdata_q <= bus.wdata_i;
               cnt_q   <= WAIT_INIT;
               if (oor) begin
                  state_q <= S_DONE;
                  ack_q   <= 1'b1;
                  err_q   <= 1'b1;
                  rdata_q <= '0;
               end else begin
                  state_q <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd0) state_q <= S_ACCESS;
            end
            S_ACCESS: begin
               state_q <= wr_q ? S_DONE : S_RDLAT;
               ack_q   <= wr_q;
            end
            S_RDLAT: begin
               rdata_q <= sram_rdata_i;
               ack_q   <= 1'b1;
               state_q <= S_DONE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
   assign bus.ack_o    = ack_q;
   assign bus.err_o    = err_q;
   assign bus.rdata_o  = rdata_q;
   assign sram_addr_o  = sram_addr_q;
   assign sram_we_o    = sram_we_q;
   assign sram_wdata_o = sram_wdata_q;
endmodule

// File: tb/tb_sram_req_bridge.sv
// tb_sram_req_bridge: randomized self-checking bench for sram_req_bridge (WAIT_CYCLES 0 and 3)
module tb_sram_req_bridge;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req = 2'b00;
   logic        wr_s = 1'b0;
   logic [31:0] addr_s = '0;
   logic [31:0] wdata_s = '0;
   logic        cur = 1'b0;
   int          n_tests = 0;
   int          n_fail = 0;
   always #5 clk = ~clk;
   sram_req_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
   sram_req_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
   assign bus0.req_i = req[0];
   assign bus0.wr_i = wr_s;
   assign bus0.addr_i = addr_s;
   assign bus0.wdata_i = wdata_s;
   assign bus1.req_i = req[1];
   assign bus1.wr_i = wr_s;
   assign bus1.addr_i = addr_s;
   assign bus1.wdata_i = wdata_s;
   logic [31:0] sa0, sw0, sr0, sa1, sw1, sr1;
   logic        we0, we1;
   sram_req_bridge #(.WAIT_CYCLES(0)) u0 (
      .clk(clk), .rst(rst), .bus(bus0),
      .sram_addr_o(sa0), .sram_we_o(we0), .sram_wdata_o(sw0), .sram_rdata_i(sr0));
   sram_req_bridge #(.WAIT_CYCLES(3)) u3 (
      .clk(clk), .rst(rst), .bus(bus1),
      .sram_addr_o(sa1), .sram_we_o(we1), .sram_wdata_o(sw1), .sram_rdata_i(sr1));
   // SRAM models: one-cycle read latency, unwritten words read as 0, addresses alias on [15:2]
   logic [31:0] mem0 [int];
   logic [31:0] mem1 [int];
   always @(posedge clk) begin
      sr0 <= mem0.exists(int'(sa0[15:2])) ? mem0[int'(sa0[15:2])] : 32'h0;
      if (we0) mem0[int'(sa0[15:2])] = sw0;
   end
   always @(posedge clk) begin
      sr1 <= mem1.exists(int'(sa1[15:2])) ? mem1[int'(sa1[15:2])] : 32'h0;
      if (we1) mem1[int'(sa1[15:2])] = sw1;
   end
   logic        o_ack, o_err, o_we;
   logic [31:0] o_rd, o_sa, o_sw;
   assign o_ack = cur ? bus1.ack_o : bus0.ack_o;
   assign o_err = cur ? bus1.err_o : bus0.err_o;
   assign o_rd  = cur ? bus1.rdata_o : bus0.rdata_o;
   assign o_we  = cur ? we1 : we0;
   assign o_sa  = cur ? sa1 : sa0;
   assign o_sw  = cur ? sw1 : sw0;
   // reference model: word store per bridge plus the rdata value each bridge should be holding
   logic [31:0] ref_mem [int];
   logic [31:0] held [2];
   function automatic int ws(input int s);
      return s == 1 ? 3 : 0;
   endfunction
   function automatic int key(input int s, input logic [31:0] a);
      return s * 16384 + int'(a[15:2]);
   endfunction
   function automatic bit is_oor(input logic [31:0] a);
`ifdef MEM_RANGE_CHECK_EN
      return a[31:2] >= 30'd16384;
`else
      return a[31:2] != a[31:2];
`endif
   endfunction
   function automatic logic [31:0] ref_rd(input int s, input logic [31:0] a);
      return ref_mem.exists(key(s, a)) ? ref_mem[key(s, a)] : 32'h0;
   endfunction
   int          lat, wes;
   logic [31:0] wa, wd, rd;
   bit          er, early, ack2;
   task automatic run_access(input int s, input bit w, input logic [31:0] a, input logic [31:0] d, input bit scr);
      logic [31:0] prev;
      cur = 1'(s);
      @(negedge clk);
      prev = o_sa;
      wr_s = w; addr_s = a; wdata_s = d; req[s] = 1'b1;
      lat = 0; wes = 0; wa = '0; wd = '0; rd = '0; er = 1'b0; early = 1'b0; ack2 = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (o_we) begin wes++; wa = o_sa; wd = o_sw; end
         if (n <= ws(s) && (o_we || o_sa !== prev)) early = 1'b1;
         if (o_ack) begin lat = n; rd = o_rd; er = o_err; req[s] = 1'b0; break; end
         if (scr) begin
            wr_s = 1'($urandom); addr_s = $urandom; wdata_s = $urandom;
            if ($urandom_range(0, 1) == 1) req[s] = 1'b0;
         end
      end
      req[s] = 1'b0;
      @(posedge clk); #1;
      ack2 = o_ack;
      if (o_we) wes++;
   endtask
   task automatic test_reset();
      rst = 1'b1; req = 2'b00;
      repeat (3) @(posedge clk);
      for (int ph = 0; ph < 2; ph++) begin
         if (ph == 0) @(negedge clk);
         else begin rst = 1'b0; @(posedge clk); #1; end
         for (int s = 0; s < 2; s++) begin
            cur = 1'(s); #1;
            n_tests++; if ({o_ack, o_err, o_we} !== 3'b000) begin n_fail++; $display("FAIL reset_ctl dut%0d ph%0d got %b want 000", s, ph, {o_ack, o_err, o_we}); end
            n_tests++; if (o_rd !== 32'h0) begin n_fail++; $display("FAIL reset_rdata dut%0d ph%0d got %h want 0", s, ph, o_rd); end
            n_tests++; if (o_sa !== 32'h0) begin n_fail++; $display("FAIL reset_saddr dut%0d ph%0d got %h want 0", s, ph, o_sa); end
            n_tests++; if (o_sw !== 32'h0) begin n_fail++; $display("FAIL reset_swdata dut%0d ph%0d got %h want 0", s, ph, o_sw); end
         end
      end
      held[0] = '0; held[1] = '0;
   endtask
   task automatic test_write_read();
      run_access(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
      ref_mem[key(0, 32'h10)] = 32'hDEADBEEF;
      n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL wr_latency got %0d want 2", lat); end
      n_tests++; if (wes !== 1) begin n_fail++; $display("FAIL wr_strobes got %0d want 1", wes); end
      n_tests++; if (wa !== 32'h10 || wd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_bus got %h/%h want 10/deadbeef", wa, wd); end
      n_tests++; if (ack2 !== 1'b0) begin n_fail++; $display("FAIL wr_ack_width got %b want 0", ack2); end
      run_access(0, 1'b0, 32'h13, 32'h0, 1'b0);
      held[0] = 32'hDEADBEEF;
      n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL rd_latency got %0d want 3", lat); end
      n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data got %h want deadbeef", rd); end
      n_tests++; if (wes !== 0 || ack2 !== 1'b0) begin n_fail++; $display("FAIL rd_strobe_ack got %0d/%b want 0/0", wes, ack2); end
   endtask
   task automatic test_wait_states();
      logic [31:0] d;
      d = $urandom;
      run_access(1, 1'b1, 32'h20, d, 1'b1);
      ref_mem[key(1, 32'h20)] = d;
      n_tests++; if (lat !== 5 || early !== 1'b0) begin n_fail++; $display("FAIL wait_wr got lat %0d early %b want 5 0", lat, early); end
      n_tests++; if (wes !== 1 || wd !== d) begin n_fail++; $display("FAIL wait_wr_bus got %0d/%h want 1/%h", wes, wd, d); end
      run_access(1, 1'b0, 32'h20, 32'h0, 1'b1);
      held[1] = d;
      n_tests++; if (lat !== 6 || early !== 1'b0) begin n_fail++; $display("FAIL wait_rd got lat %0d early %b want 6 0", lat, early); end
      n_tests++; if (rd !== d) begin n_fail++; $display("FAIL wait_rd_data got %h want %h", rd, d); end
   endtask
   task automatic test_back_to_back();
      int t1, t2;
      cur = 1'b0;
      @(negedge clk);
      wr_s = 1'b1; addr_s = 32'h0; wdata_s = 32'h1; req[0] = 1'b1;
      t1 = 0; t2 = 0; rd = '0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (o_ack) begin t1 = n; break; end
      end
      wr_s = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (o_ack) begin t2 = n; rd = o_rd; break; end
      end
      req[0] = 1'b0;
      ref_mem[key(0, 32'h0)] = 32'h1;
      held[0] = 32'h1;
      @(posedge clk); #1;
      n_tests++; if (t1 !== 2) begin n_fail++; $display("FAIL b2b_first_ack got %0d want 2", t1); end
      n_tests++; if (t2 !== 4) begin n_fail++; $display("FAIL b2b_gap got %0d want 4", t2); end
      n_tests++; if (rd !== 32'h1) begin n_fail++; $display("FAIL b2b_rdata got %h want 1", rd); end
   endtask
   task automatic test_reset_mid_access();
      int bad;
      bad = 0;
      cur = 1'b1;
      @(negedge clk);
      wr_s = 1'b1; addr_s = 32'h30; wdata_s = 32'hA5A50000 | ($urandom & 32'hFFFF); req[1] = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1; req[1] = 1'b0;
      repeat (2) begin @(posedge clk); #1; if (o_we || o_ack) bad++; end
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 8; n++) begin
         @(posedge clk); #1;
         if (o_we || o_ack) bad++;
         if (n == 0) begin
            n_tests++; if ({o_err, o_rd, o_sa, o_sw} !== 97'h0) begin n_fail++; $display("FAIL rst_mid_outputs got err %b rd %h sa %h sw %h want 0", o_err, o_rd, o_sa, o_sw); end
         end
      end
      held[0] = '0; held[1] = '0;
      n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL rst_mid_activity got %0d want 0", bad); end
      run_access(1, 1'b0, 32'h30, 32'h0, 1'b0);
      held[1] = ref_rd(1, 32'h30);
      n_tests++; if (lat !== 6 || rd !== ref_rd(1, 32'h30)) begin n_fail++; $display("FAIL rst_mid_aborted got lat %0d rd %h want 6 %h", lat, rd, ref_rd(1, 32'h30)); end
      run_access(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
      n_tests++; if (lat !== 2 || wes !== 1 || wa !== 32'h10) begin n_fail++; $display("FAIL rst_mid_next got lat %0d we %0d sa %h want 2 1 10", lat, wes, wa); end
   endtask
   task automatic test_range();
      run_access(0, 1'b1, 32'h10000, 32'h5A5A1234, 1'b0);
`ifdef MEM_RANGE_CHECK_EN
      held[0] = '0;
      n_tests++; if (lat !== 1 || er !== 1'b1) begin n_fail++; $display("FAIL range_err got lat %0d err %b want 1 1", lat, er); end
      n_tests++; if (wes !== 0 || rd !== 32'h0) begin n_fail++; $display("FAIL range_side got we %0d rd %h want 0 0", wes, rd); end
`else
      ref_mem[key(0, 32'h10000)] = 32'h5A5A1234;
      n_tests++; if (lat !== 2 || er !== 1'b0) begin n_fail++; $display("FAIL range_off got lat %0d err %b want 2 0", lat, er); end
      n_tests++; if (wes !== 1 || wa !== 32'h10000) begin n_fail++; $display("FAIL range_off_bus got we %0d sa %h want 1 10000", wes, wa); end
      run_access(0, 1'b0, 32'h0, 32'h0, 1'b0);
      held[0] = 32'h5A5A1234;
      n_tests++; if (rd !== 32'h5A5A1234) begin n_fail++; $display("FAIL range_alias got %h want 5a5a1234", rd); end
`endif
   endtask
   task automatic test_random();
      int s, el;
      bit w, o;
      logic [31:0] a, d, er_rd;
      for (int i = 0; i < 60; i++) begin
         s = $urandom_range(0, 1);
         w = 1'($urandom_range(0, 1));
         a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 3)) << 16);
         d = $urandom;
         o = is_oor(a);
         el = o ? 1 : ws(s) + (w ? 2 : 3);
         er_rd = o ? 32'h0 : (w ? held[s] : ref_rd(s, a));
         run_access(s, w, a, d, 1'($urandom_range(0, 1)));
         if (w && !o) ref_mem[key(s, a)] = d;
         if (o || !w) held[s] = er_rd;
         n_tests++; if (lat !== el || ack2 !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_latency got %0d/%b want %0d/0", i, lat, ack2, el); end
         n_tests++; if (wes !== int'(w && !o) || early !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_strobe got %0d early %b want %0d", i, wes, early, int'(w && !o)); end
         n_tests++; if (rd !== er_rd || er !== o) begin n_fail++; $display("FAIL rnd%0d_rdata got %h err %b want %h %b", i, rd, er, er_rd, o); end
         if (w && !o) begin
            n_tests++; if (wa !== (a & ~32'h3) || wd !== d) begin n_fail++; $display("FAIL rnd%0d_wbus got %h/%h want %h/%h", i, wa, wd, a & ~32'h3, d); end
         end
      end
   endtask
   initial begin
      test_reset();
      test_write_read();
      test_wait_states();
      test_back_to_back();
      test_reset_mid_access();
      test_range();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
